// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: a valid/ready command becomes one SETUP/ACCESS
// transfer, and its result returns on a valid/ready response port.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;

  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_timeout_reg, rsp_timeout_next;

  logic              rd_keep;
  logic [DATA_W-1:0] rdata_masked;

  // Read data is only captured for a clean read completion; writes and errors return zero.
  assign rd_keep = pready & ~pwrite_reg & ~pslverr;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rdata_mask
      assign rdata_masked[gi] = prdata[gi] & rd_keep;
    end
  endgenerate

  assign cmd_ready = (state_reg == ST_IDLE);

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_next  = cmd_write;
          paddr_next   = cmd_addr;
          pwdata_next  = cmd_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
        state_next   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_err_next     = pslverr;
          rsp_timeout_next = 1'b0;
          rsp_rdata_next   = rdata_masked;
          rsp_valid_next   = 1'b1;
          state_next       = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          // Completer never answered: terminate so the bridge cannot hang.
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = '0;
          rsp_valid_next   = 1'b1;
          state_next       = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule
